// File: rtl/audio_frame_streamer.sv
// Drains one frame per capture from the I2S input buffer: snapshots all mono heads,
// pops them with a single read strobe, then serialises the snapshot as a tagged valid/ready stream.
module audio_frame_streamer #(
  parameter int AUDIO_WIDTH        = 24,
  parameter int NUM_AUDIO_CHANNELS = 8,
  parameter int STEREO_MULTIPLIER  = 2,
  localparam int N    = NUM_AUDIO_CHANNELS * STEREO_MULTIPLIER,
  localparam int ID_W = $clog2(N)
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic                            stream_en,
  input  logic                            buffer_ready,
  input  logic                            buffer_full,
  input  logic [N-1:0][AUDIO_WIDTH-1:0]   audio_channel_in,
  output logic                            adv_read_enable,
  output logic [AUDIO_WIDTH-1:0]          m_tdata,
  output logic [ID_W-1:0]                 m_tid,
  output logic                            m_tlast,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            busy,
  output logic [31:0]                     frame_count,
  output logic [15:0]                     overflow_count
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                          state;
  logic [N-1:0][AUDIO_WIDTH-1:0]   snap;
  logic [ID_W-1:0]                 idx;
  logic                            full_prev;
  logic [15:0]                     ovf_cnt;

  // Capture and serialise; adv_read_enable is a one-cycle pulse following each capture edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      snap            <= '0;
      idx             <= '0;
      adv_read_enable <= 1'b0;
      frame_count     <= '0;
    end else begin
      adv_read_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (stream_en && buffer_ready) begin
            snap            <= audio_channel_in;
            idx             <= '0;
            state           <= STREAM;
            adv_read_enable <= 1'b1;
          end
        end
        STREAM: begin
          if (m_tready) begin
            if (idx == LAST_IDX) begin
              idx         <= '0;
              frame_count <= frame_count + 32'd1;
              state       <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overflow monitor runs regardless of the FSM; counts rising edges and saturates.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      full_prev <= 1'b0;
      ovf_cnt   <= '0;
    end else begin
      full_prev <= buffer_full;
      if (buffer_full && !full_prev && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

  // Beat outputs come straight from registers, so they stay stable under backpressure.
  assign busy           = (state == STREAM);
  assign m_tvalid       = busy;
  assign m_tid          = idx;
  assign m_tlast        = busy && (idx == LAST_IDX);
  assign m_tdata        = snap[idx];
  assign overflow_count = ovf_cnt;

endmodule

// File: tb/tb_audio_frame_streamer.sv
// Directed bench for audio_frame_streamer: a cycle table for backpressure plus
// hand-written sequences for reset, single frame, continuous run, stream_en drop and overflow.
module tb_audio_frame_streamer;
  localparam int N = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0, br = 1'b0, bf = 1'b0, rdy = 1'b0;
  logic [N-1:0][23:0] ch;
  logic              adv, tlast, tvalid, busy;
  logic [23:0]       tdata;
  logic [3:0]        tid;
  logic [31:0]       fc;
  logic [15:0]       oc;

  int n_cmp = 0;
  int n_bad = 0;

  audio_frame_streamer dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .stream_en(en), .buffer_ready(br),
    .buffer_full(bf), .audio_channel_in(ch), .adv_read_enable(adv),
    .m_tdata(tdata), .m_tid(tid), .m_tlast(tlast), .m_tvalid(tvalid),
    .m_tready(rdy), .busy(busy), .frame_count(fc), .overflow_count(oc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, br, rdy, chg;
    logic       vld;
    logic [3:0] tid;
    logic       last, adv;
  } row_t;

  row_t rows[22];

  function automatic row_t mk(logic e, logic b, logic r, logic c, logic v,
                              logic [3:0] t, logic l, logic a);
    row_t x;
    x.en = e; x.br = b; x.rdy = r; x.chg = c; x.vld = v; x.tid = t; x.last = l; x.adv = a;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [23:0] base);
    for (int i = 0; i < N; i++) ch[i] = base + 24'(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; br = 1'b0; bf = 1'b0; rdy = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int beats, advs, fc0, last_pulse, pulse_no;
    load(24'h100000);

    // Reset state
    do_reset();
    chk("rst tvalid", 32'(tvalid), 32'd0);
    chk("rst adv", 32'(adv), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst fc", fc, 32'd0);
    chk("rst oc", 32'(oc), 32'd0);
    chk("rst tdata", 32'(tdata), 32'd0);

    // T2: single frame with m_tready held high
    load(24'h100000);
    rdy = 1'b1; en = 1'b1; br = 1'b1;
    step();
    br = 1'b0;
    beats = 0; advs = 0;
    for (int c = 0; c < 40 && beats < 16; c++) begin
      if (adv) advs++;
      if (tvalid) begin
        chk($sformatf("t2 tid b%0d", beats), 32'(tid), 32'(beats));
        chk($sformatf("t2 tdata b%0d", beats), 32'(tdata), 32'(24'h100000 + 24'(beats)));
        chk($sformatf("t2 tlast b%0d", beats), 32'(tlast), 32'(beats == 15));
      end
      if (tvalid) beats++;
      step();
    end
    for (int c = 0; c < 5; c++) begin
      if (adv) advs++;
      step();
    end
    chk("t2 beats", 32'(beats), 32'd16);
    chk("t2 adv pulses", 32'(advs), 32'd1);
    chk("t2 fc", fc, 32'd1);
    chk("t2 idle tvalid", 32'(tvalid), 32'd0);

    // T1: async reset right after a capture, with nonzero counters
    bf = 1'b1; step(); bf = 1'b0; step();
    chk("t1 pre oc", 32'(oc), 32'd1);
    br = 1'b1; step(); br = 1'b0;
    chk("t1 pre adv", 32'(adv), 32'd1);
    chk("t1 pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1 tvalid", 32'(tvalid), 32'd0);
    chk("t1 adv", 32'(adv), 32'd0);
    chk("t1 busy", 32'(busy), 32'd0);
    chk("t1 fc", fc, 32'd0);
    chk("t1 oc", 32'(oc), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // T3: backpressure at tid 3 for 5 cycles, inputs changed while stalled,
    // buffer_ready pulsed mid-frame with no effect
    rows[0] = mk(1, 1, 1, 0, 1, 4'd0, 0, 1);
    rows[1] = mk(1, 0, 1, 0, 1, 4'd1, 0, 0);
    rows[2] = mk(1, 0, 1, 0, 1, 4'd2, 0, 0);
    rows[3] = mk(1, 0, 1, 0, 1, 4'd3, 0, 0);
    rows[4] = mk(1, 0, 0, 0, 1, 4'd3, 0, 0);
    rows[5] = mk(1, 0, 0, 1, 1, 4'd3, 0, 0);
    rows[6] = mk(1, 0, 0, 0, 1, 4'd3, 0, 0);
    rows[7] = mk(1, 0, 0, 0, 1, 4'd3, 0, 0);
    rows[8] = mk(1, 0, 0, 0, 1, 4'd3, 0, 0);
    for (int i = 9; i <= 20; i++) rows[i] = mk(1, 0, 1, 0, 1, 4'(i - 5), i == 20, 0);
    rows[10].br = 1'b1;
    rows[21] = mk(0, 0, 1, 0, 0, 4'd0, 0, 0);

    do_reset();
    load(24'h100000);
    for (int i = 0; i < 22; i++) begin
      en = rows[i].en; br = rows[i].br; rdy = rows[i].rdy;
      if (rows[i].chg) load(24'hABC000);
      step();
      chk($sformatf("t3 tvalid r%0d", i), 32'(tvalid), 32'(rows[i].vld));
      chk($sformatf("t3 busy r%0d", i), 32'(busy), 32'(rows[i].vld));
      chk($sformatf("t3 adv r%0d", i), 32'(adv), 32'(rows[i].adv));
      if (rows[i].vld) begin
        chk($sformatf("t3 tid r%0d", i), 32'(tid), 32'(rows[i].tid));
        chk($sformatf("t3 tlast r%0d", i), 32'(tlast), 32'(rows[i].last));
        chk($sformatf("t3 tdata r%0d", i), 32'(tdata), 32'(24'h100000 + 24'(rows[i].tid)));
      end
    end
    chk("t3 fc", fc, 32'd1);

    // T4: continuous run, 100 edges; captures land on edges 1,18,...,86 and
    // completions on 17,...,85, so 6 pulses, 5 frames, 6th frame at tid 14
    do_reset();
    load(24'h200000);
    en = 1'b1; br = 1'b1; rdy = 1'b1;
    advs = 0; fc0 = 0; last_pulse = 0; pulse_no = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (adv) begin
        advs++;
        if (pulse_no > 0) chk($sformatf("t4 period p%0d", pulse_no), 32'(c - last_pulse), 32'd17);
        last_pulse = c;
        pulse_no++;
      end
    end
    chk("t4 fc", fc, 32'd5);
    chk("t4 adv pulses", 32'(advs), 32'd6);
    chk("t4 busy", 32'(busy), 32'd1);
    chk("t4 tid", 32'(tid), 32'd14);

    // T5: stream_en dropped at tid 7 while buffer_ready stays high
    do_reset();
    load(24'h300000);
    en = 1'b1; br = 1'b1; rdy = 1'b1;
    beats = 0; advs = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (adv) advs++;
      if (tvalid) begin
        chk($sformatf("t5 tid b%0d", beats), 32'(tid), 32'(beats));
        if (tid == 4'd7) en = 1'b0;
        beats++;
      end
    end
    chk("t5 beats", 32'(beats), 32'd16);
    chk("t5 adv pulses", 32'(advs), 32'd1);
    chk("t5 fc", fc, 32'd1);
    chk("t5 busy", 32'(busy), 32'd0);

    // T6: overflow edges, one held high for several cycles, then saturation
    do_reset();
    for (int e = 0; e < 3; e++) begin
      bf = 1'b1;
      repeat (e == 1 ? 3 : 1) step();
      bf = 1'b0;
      step(); step();
    end
    chk("t6 oc three", 32'(oc), 32'd3);
    chk("t6 busy", 32'(busy), 32'd0);
    force dut.ovf_cnt = 16'hFFFE;
    #1;
    release dut.ovf_cnt;
    step();
    bf = 1'b1; step(); bf = 1'b0; step();
    chk("t6 oc max", 32'(oc), 32'h0000FFFF);
    bf = 1'b1; step(); bf = 1'b0; step();
    chk("t6 oc sat", 32'(oc), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end
endmodule
